// File: rtl/reg_stream_reader_if.sv
// Handshake and register-bank bus of the streaming register reader.
// The master modport is the reader itself; the slave modport is the
// environment that owns the bank and consumes the word stream.
interface reg_stream_reader_if #(
    parameter int unsigned NUM_BIT = 8,
    parameter int unsigned NUM_REG = 4
);
    localparam int unsigned ADDR_W = (NUM_REG > 2) ? $clog2(NUM_REG) : 1;

    logic              start;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] rd_addr;
    logic [NUM_BIT-1:0] rd_data;
    logic [NUM_BIT-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        input  start, len, rd_data, out_ready,
        output rd_addr, out_data, out_valid, out_last, busy, done
    );

    modport slave (
        output start, len, rd_data, out_ready,
        input  rd_addr, out_data, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/reg_stream_reader.sv
// Reads up to NUM_REG words from a combinational register bank, starting at
// address 0, and streams them out one word at a time over a valid/ready
// handshake. Every output is registered; one word per two cycles at most.
module reg_stream_reader #(
    parameter int unsigned NUM_BIT = 8,
    parameter int unsigned NUM_REG = 4
) (
    input  logic               clk,
    input  logic               reset,
    reg_stream_reader_if.master bus
);
    localparam int unsigned ADDR_W = (NUM_REG > 2) ? $clog2(NUM_REG) : 1;
    localparam logic [ADDR_W:0] REG_CNT = (ADDR_W + 1)'(NUM_REG);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   eff_len;

    logic [ADDR_W:0]   len_clamped;
    logic              last_word;
    logic              handshake;
    logic [ADDR_W-1:0] idx_next;

    // Length clamp, last-word detect and handshake qualification.
    always_comb begin
        len_clamped = (bus.len > REG_CNT) ? REG_CNT : bus.len;
        last_word   = ({1'b0, idx} == (eff_len - LEN_ONE));
        handshake   = bus.out_valid & bus.out_ready;
        idx_next    = idx + IDX_ONE;
    end

    // Sequencer: state, index and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            eff_len       <= '0;
            bus.rd_addr   <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.done      <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        eff_len     <= len_clamped;
                        idx         <= '0;
                        bus.rd_addr <= '0;
                        bus.busy    <= 1'b1;
                        if (len_clamped != '0) begin
                            state <= FETCH;
                        end else begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    bus.out_data  <= bus.rd_data;
                    bus.out_valid <= 1'b1;
                    bus.out_last  <= last_word;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (handshake) begin
                        bus.out_valid <= 1'b0;
                        if (bus.out_last) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            idx         <= idx_next;
                            bus.rd_addr <= idx_next;
                            state       <= FETCH;
                        end
                    end
                end
                DONE: begin
                    bus.out_last <= 1'b0;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_stream_reader.sv
// Directed bench for reg_stream_reader with NUM_BIT=8, NUM_REG=4 and a
// four-entry bank {0x11,0x22,0x33,0x44}.
module tb_reg_stream_reader;
    logic clk = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int failures = 0;

    int done_count = 0;
    int hs_count = 0;
    bit overlap_seen = 1'b0;
    bit addr_over = 1'b0;

    logic [7:0] bank [0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};

    reg_stream_reader_if #(.NUM_BIT(8), .NUM_REG(4)) bus ();

    reg_stream_reader #(.NUM_BIT(8), .NUM_REG(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.rd_data = bank[bus.rd_addr];

    always #5 clk = ~clk;

    // Observe pulses and invariants between active edges.
    always @(negedge clk) begin
        if (bus.done === 1'b1) done_count++;
        if (bus.done === 1'b1 && bus.out_valid === 1'b1) overlap_seen = 1'b1;
        if (!reset && bus.rd_addr > 2'd3) addr_over = 1'b1;
    end

    // Count accepted words at the edge where they are taken.
    always @(posedge clk) begin
        if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) hs_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'h0);
        check({tag, "_out_data"}, 32'(bus.out_data), 32'h0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
        check({tag, "_out_last"}, 32'(bus.out_last), 32'h0);
        check({tag, "_done"}, 32'(bus.done), 32'h0);
        check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    endtask

    // One sequence with out_ready held high; optionally keeps start high
    // for the whole sequence to show it is ignored while busy.
    task automatic run_full(input string tag, input int unsigned ln,
                            input int unsigned nwords, input bit poke);
        bus.len = 3'(ln);
        bus.start = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.start = poke;
        bus.len = 3'd0;
        check({tag, "_t1_busy"}, 32'(bus.busy), 32'h1);
        check({tag, "_t1_valid"}, 32'(bus.out_valid), 32'h0);
        for (int unsigned w = 0; w < nwords; w++) begin
            tick();
            check({tag, "_valid"}, 32'(bus.out_valid), 32'h1);
            check({tag, "_data"}, 32'(bus.out_data), 32'(bank[w]));
            check({tag, "_last"}, 32'(bus.out_last), (w == nwords - 1) ? 32'h1 : 32'h0);
            check({tag, "_addr"}, 32'(bus.rd_addr), 32'(w));
            check({tag, "_done_early"}, 32'(bus.done), 32'h0);
            tick();
            check({tag, "_gap_valid"}, 32'(bus.out_valid), 32'h0);
            check({tag, "_done"}, 32'(bus.done), (w == nwords - 1) ? 32'h1 : 32'h0);
        end
        bus.start = 1'b0;
        tick();
        check({tag, "_end_done"}, 32'(bus.done), 32'h0);
        check({tag, "_end_busy"}, 32'(bus.busy), 32'h0);
    endtask

    initial begin
        int dc_before;
        bus.start = 1'b0;
        bus.len = 3'd0;
        bus.out_ready = 1'b0;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check_idle_zero("reset");
        reset = 1'b0;
        tick();

        // Four words, ready always high
        run_full("full4", 4, 4, 1'b0);

        // len=3 with backpressure on word 1 for five cycles
        bus.len = 3'd3;
        bus.start = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        check("bp_t1_busy", 32'(bus.busy), 32'h1);
        tick();
        check("bp_w0_valid", 32'(bus.out_valid), 32'h1);
        check("bp_w0_data", 32'(bus.out_data), 32'h11);
        check("bp_w0_last", 32'(bus.out_last), 32'h0);
        tick();
        check("bp_gap0", 32'(bus.out_valid), 32'h0);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_valid", 32'(bus.out_valid), 32'h1);
            check("bp_hold_data", 32'(bus.out_data), 32'h22);
            check("bp_hold_last", 32'(bus.out_last), 32'h0);
            check("bp_hold_addr", 32'(bus.rd_addr), 32'h1);
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_gap1", 32'(bus.out_valid), 32'h0);
        tick();
        check("bp_w2_valid", 32'(bus.out_valid), 32'h1);
        check("bp_w2_data", 32'(bus.out_data), 32'h33);
        check("bp_w2_last", 32'(bus.out_last), 32'h1);
        tick();
        check("bp_done", 32'(bus.done), 32'h1);
        check("bp_done_valid", 32'(bus.out_valid), 32'h0);
        tick();
        check("bp_end_done", 32'(bus.done), 32'h0);
        check("bp_end_busy", 32'(bus.busy), 32'h0);

        // len=0: done and busy for exactly one cycle, no word
        check("len0_pre_busy", 32'(bus.busy), 32'h0);
        bus.len = 3'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("len0_done", 32'(bus.done), 32'h1);
        check("len0_busy", 32'(bus.busy), 32'h1);
        check("len0_valid", 32'(bus.out_valid), 32'h0);
        tick();
        check("len0_end_done", 32'(bus.done), 32'h0);
        check("len0_end_busy", 32'(bus.busy), 32'h0);
        check("len0_end_valid", 32'(bus.out_valid), 32'h0);

        // len=7 clamps to four words
        run_full("len7", 7, 4, 1'b0);

        // Reset while holding word 2, then restart immediately
        bus.len = 3'd4;
        bus.start = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("abort_w0", 32'(bus.out_data), 32'h11);
        tick();
        tick();
        check("abort_w1", 32'(bus.out_data), 32'h22);
        tick();
        bus.out_ready = 1'b0;
        tick();
        check("abort_w2_valid", 32'(bus.out_valid), 32'h1);
        check("abort_w2_data", 32'(bus.out_data), 32'h33);
        check("abort_w2_addr", 32'(bus.rd_addr), 32'h2);
        dc_before = done_count;
        reset = 1'b1;
        tick();
        check_idle_zero("abort_rst");
        reset = 1'b0;
        check("abort_no_done", 32'(done_count), 32'(dc_before));
        run_full("restart", 4, 4, 1'b0);

        // start held high during an active sequence is ignored
        run_full("poke", 2, 2, 1'b1);

        // Global invariants
        check("done_valid_overlap", 32'(overlap_seen), 32'h0);
        check("rd_addr_range", 32'(addr_over), 32'h0);
        check("done_pulse_count", 32'(done_count), 32'd6);
        check("handshake_count", 32'(hs_count), 32'd19);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
